// File: rtl/lstm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lstm_pkg
// Description : Shared constants and types for the LSTM hidden-state
//               collector: word width, hidden-layer size, the ht word type
//               and the read-side state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package lstm_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int NUM_HIDDEN = 64;

    typedef logic [DATA_WIDTH-1:0] ht_word_t;

    // Read-side sequencing: wait for a full bank, prime the RAM read
    // pipeline, then stream words out to the sink.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2
    } rd_state_t;

endpackage : lstm_pkg
`default_nettype wire

// File: rtl/lstm_ht_collector_ram.sv
`default_nettype none
// ============================================================================
// Module      : ht_bank_ram
// Description : Simple dual-port RAM holding both ping-pong banks of ht
//               words. Address is {bank, index}. One write port, one read
//               port with a registered output (one cycle read latency).
// Ports       : clk      - clock
//               wr_en    - write strobe
//               wr_addr  - write address {bank, index}
//               wr_data  - write data
//               rd_addr  - read address {bank, index}, sampled every cycle
//               rd_data  - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module ht_bank_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 7
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_W)-1];

    // Contents carry no reset; the top never reads a word it has not written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        rd_data <= r_mem[rd_addr];
    end

endmodule : ht_bank_ram
`default_nettype wire

// File: rtl/lstm_ht_collector.sv
`default_nettype none
// ============================================================================
// Module      : lstm_ht_collector
// Description : Collects each timestep's NUM_HIDDEN ht words from the LSTM
//               into a two-bank ping-pong buffer and re-emits every complete
//               vector over a valid/ready stream with index and last markers.
//               Tracks drained timesteps, overflow, framing errors and
//               end-of-run.
// Ports       : clk            - clock
//               reset          - synchronous, active-low reset
//               ht_valid       - ht_out valid this cycle
//               ht_out         - hidden-state word from the LSTM
//               cycle_complete - end-of-timestep pulse
//               done_in        - LSTM run finished (level)
//               out_valid      - out_data valid
//               out_ready      - sink accepts the presented word
//               out_data       - buffered ht word
//               out_index      - neuron index of out_data
//               out_last       - final word of the vector
//               timestep_count - vectors fully drained (saturating)
//               overflow       - sticky: a word was dropped (bank full)
//               frame_error    - sticky: cycle_complete on a partial vector
//               all_done       - sticky: run finished and fully drained
// Revision    : 1.0 - initial release
// ============================================================================
module lstm_ht_collector #(
    parameter int DATA_WIDTH = lstm_pkg::DATA_WIDTH,
    parameter int NUM_HIDDEN = lstm_pkg::NUM_HIDDEN,
    parameter int IDX_W      = $clog2(NUM_HIDDEN),
    parameter int TS_W       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ht_valid,
    input  logic [DATA_WIDTH-1:0] ht_out,
    input  logic                  cycle_complete,
    input  logic                  done_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [IDX_W-1:0]      out_index,
    output logic                  out_last,
    output logic [TS_W-1:0]       timestep_count,
    output logic                  overflow,
    output logic                  frame_error,
    output logic                  all_done
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_HIDDEN - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]      r_wr_ptr;
    logic                  r_wr_bank;
    logic [1:0]            r_full;
    logic                  r_rd_bank;
    logic [IDX_W-1:0]      r_rd_idx;
    lstm_pkg::rd_state_t   r_state;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [TS_W-1:0]       r_ts_count;
    logic                  r_overflow;
    logic                  r_frame_error;
    logic                  r_done_seen;
    logic                  r_all_done;

    logic                  w_wr_accept;
    logic                  w_wr_close;
    logic                  w_partial;
    logic                  w_hs;
    logic                  w_last;
    logic                  w_release;
    logic [1:0]            w_full_next;
    logic [IDX_W-1:0]      w_rd_idx;
    logic [DATA_WIDTH-1:0] w_ram_rd_data;

    // ------------------------------------------------------------------
    // Write side decode. Full flags are the registered (pre-edge) values,
    // so a bank being released this cycle still rejects the write.
    // ------------------------------------------------------------------
    assign w_wr_accept = ht_valid && !r_full[r_wr_bank];
    assign w_wr_close  = w_wr_accept && (r_wr_ptr == c_last_idx);
    // A closing write may coincide with cycle_complete; anything else that
    // leaves words in the current vector is a framing error.
    assign w_partial   = cycle_complete && !w_wr_close &&
                         ((r_wr_ptr != '0) || w_wr_accept);

    // ------------------------------------------------------------------
    // Read side decode
    // ------------------------------------------------------------------
    assign w_hs      = r_out_valid && out_ready;
    assign w_last    = r_out_valid && (r_rd_idx == c_last_idx);
    assign w_release = w_hs && w_last;

    always_comb begin
        w_full_next = r_full;
        if (w_wr_close) begin
            w_full_next[r_wr_bank] = 1'b1;
        end
        if (w_release) begin
            w_full_next[r_rd_bank] = 1'b0;
        end
    end

    // Read-ahead addressing: while streaming word k the RAM output register
    // already holds word k+1, so a handshake can load the next word with no
    // bubble. On a handshake the address jumps to k+2 to keep one ahead.
    // IDLE primes index 0 and FETCH primes index 1.
    always_comb begin
        w_rd_idx = '0;
        case (r_state)
            lstm_pkg::IDLE:   w_rd_idx = '0;
            lstm_pkg::FETCH:  w_rd_idx = IDX_W'(1);
            lstm_pkg::STREAM: w_rd_idx = r_rd_idx + IDX_W'(1) + IDX_W'(w_hs);
            default:          w_rd_idx = '0;
        endcase
    end

    ht_bank_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (IDX_W + 1)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_wr_accept),
        .wr_addr ({r_wr_bank, r_wr_ptr}),
        .wr_data (ht_out),
        .rd_addr ({r_rd_bank, w_rd_idx}),
        .rd_data (w_ram_rd_data)
    );

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr      <= '0;
            r_wr_bank     <= 1'b0;
            r_full        <= 2'b00;
            r_rd_bank     <= 1'b0;
            r_rd_idx      <= '0;
            r_state       <= lstm_pkg::IDLE;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_ts_count    <= '0;
            r_overflow    <= 1'b0;
            r_frame_error <= 1'b0;
            r_done_seen   <= 1'b0;
            r_all_done    <= 1'b0;
        end else begin
            // Write pointer / bank
            if (w_wr_accept) begin
                if (w_wr_close) begin
                    r_wr_ptr  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_ptr <= r_wr_ptr + IDX_W'(1);
                end
            end
            if (w_partial) begin
                r_wr_ptr      <= '0;
                r_frame_error <= 1'b1;
            end
            if (ht_valid && r_full[r_wr_bank]) begin
                r_overflow <= 1'b1;
            end

            r_full <= w_full_next;

            // Read FSM
            case (r_state)
                lstm_pkg::IDLE: begin
                    if (r_full[r_rd_bank]) begin
                        r_state  <= lstm_pkg::FETCH;
                        r_rd_idx <= '0;
                    end
                end
                lstm_pkg::FETCH: begin
                    r_state     <= lstm_pkg::STREAM;
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_ram_rd_data;
                end
                lstm_pkg::STREAM: begin
                    if (w_hs) begin
                        if (w_last) begin
                            r_out_valid <= 1'b0;
                            r_rd_bank   <= ~r_rd_bank;
                            r_rd_idx    <= '0;
                            r_state     <= lstm_pkg::IDLE;
                            if (r_ts_count != {TS_W{1'b1}}) begin
                                r_ts_count <= r_ts_count + TS_W'(1);
                            end
                        end else begin
                            r_rd_idx   <= r_rd_idx + IDX_W'(1);
                            r_out_data <= w_ram_rd_data;
                        end
                    end
                end
                default: r_state <= lstm_pkg::IDLE;
            endcase

            // End-of-run tracking
            if (done_in) begin
                r_done_seen <= 1'b1;
            end
            if (r_done_seen && (r_wr_ptr == '0) && (r_full == 2'b00) &&
                (r_state == lstm_pkg::IDLE)) begin
                r_all_done <= 1'b1;
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign out_data       = r_out_data;
    assign out_index      = r_rd_idx;
    assign out_last       = w_last;
    assign timestep_count = r_ts_count;
    assign overflow       = r_overflow;
    assign frame_error    = r_frame_error;
    assign all_done       = r_all_done;

endmodule : lstm_ht_collector
`default_nettype wire
